// File: rtl/fb_fill_engine_pkg.sv
// Shared definitions for the framebuffer fill engine: pattern modes and FSM state codes.
package fb_fill_engine_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_HSTRIPE = 2'd2,
    MODE_VSTRIPE = 2'd3
  } fb_mode_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT      = 2'd2;
  localparam logic [1:0] ST_FRAME_END = 2'd3;

endpackage

// File: rtl/fb_fill_engine_if.sv
// Frame RAM write port (port b): coordinates, pixel data and write/ready handshake.
interface fb_fill_engine_if #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int PIX_W = 1
);
  logic [X_W-1:0]   x_b;
  logic [Y_W-1:0]   y_b;
  logic [PIX_W-1:0] in_b;
  logic             write_b;
  logic             rdy_b;

  modport master (output x_b, output y_b, output in_b, output write_b, input rdy_b);
  modport slave  (input x_b, input y_b, input in_b, input write_b, output rdy_b);
endinterface

// File: rtl/fb_fill_engine_pattern_gen.sv
// Combinational pixel pattern generator: picks color_a or color_b from coordinates, mode and phase.
module fb_pattern_gen
  import fb_fill_engine_pkg::*;
#(
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int PIX_W     = 1,
  parameter int CELL_LOG2 = 3
) (
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  fb_mode_e         mode,
  input  logic             phase,
  input  logic [PIX_W-1:0] color_a,
  input  logic [PIX_W-1:0] color_b,
  output logic [PIX_W-1:0] pix
);

  logic sel;
  // Only the cell-select bit of each coordinate matters.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x, y};

  always_comb begin
    sel = 1'b0;
    unique case (mode)
      MODE_SOLID:   sel = 1'b0;
      MODE_CHECKER: sel = x[CELL_LOG2] ^ y[CELL_LOG2];
      MODE_HSTRIPE: sel = y[CELL_LOG2];
      MODE_VSTRIPE: sel = x[CELL_LOG2];
    endcase
    pix = (sel ^ phase) ? color_b : color_a;
  end

endmodule

// File: rtl/fb_fill_engine.sv
// Framebuffer sweep/fill engine: raster-order paced writes of a pattern into the frame RAM port b.
module fb_fill_engine
  import fb_fill_engine_pkg::*;
#(
  parameter int H_RES     = 320,
  parameter int V_RES     = 200,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int PIX_W     = 1,
  parameter int PACE_W    = 16,
  parameter int CELL_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  color_a,
  input  logic [PIX_W-1:0]  color_b,
  input  logic [PACE_W-1:0] pace,
  fb_fill_engine_if.master  wr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [1:0]        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [PACE_W-1:0] cnt_q, cnt_d;
  fb_mode_e          mode_q, mode_d;
  logic [PIX_W-1:0]  ca_q, ca_d, cb_q, cb_d;
  logic              phase_q, phase_d;
  logic              done_d;
  logic [15:0]       fcnt_d;
  logic              last_px;

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pace_d  = pace_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    fcnt_d  = frame_cnt;

    if (abort) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d  = fb_mode_e'(mode);
            ca_d    = color_a;
            cb_d    = color_b;
            pace_d  = pace;
            phase_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (wr.rdy_b) begin
            if (last_px) begin
              x_d     = '0;
              y_d     = '0;
              state_d = ST_FRAME_END;
            end else begin
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
              if (pace_q != '0) begin
                cnt_d   = PACE_W'(1);
                state_d = ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == pace_q) state_d = ST_REQ;
          else                 cnt_d   = cnt_q + 1'b1;
        end
        ST_FRAME_END: begin
          fcnt_d = frame_cnt + 1'b1;
          if (loop) begin
            phase_d = ~phase_q;
            if (pace_q != '0) begin
              cnt_d   = PACE_W'(1);
              state_d = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pixel is computed from the next coordinates so in_b registers alongside x_b/y_b.
  fb_pattern_gen #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .PIX_W    (PIX_W),
    .CELL_LOG2(CELL_LOG2)
  ) u_pattern (
    .x      (x_d),
    .y      (y_d),
    .mode   (mode_d),
    .phase  (phase_d),
    .color_a(ca_d),
    .color_b(cb_d),
    .pix    (pix_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      pix_q     <= '0;
      pace_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_SOLID;
      ca_q      <= '0;
      cb_q      <= '0;
      phase_q   <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_q     <= pix_d;
      pace_q    <= pace_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      phase_q   <= phase_d;
      done      <= done_d;
      frame_cnt <= fcnt_d;
    end
  end

  assign wr.x_b     = x_q;
  assign wr.y_b     = y_q;
  assign wr.in_b    = pix_q;
  assign wr.write_b = (state_q == ST_REQ);
  assign busy       = (state_q != ST_IDLE);

endmodule
